// File: rtl/fifo_stream_out_if.sv
// -----------------------------------------------------------------------------
// fifo_stream_out_if
//   Bundles the fifo read side and the valid/ready stream side of the
//   fifo_stream_out drain stage.
//
//   fifo_empty  fifo empty flag                  (fifo -> drain)
//   fifo_q      fifo read data, one cycle late   (fifo -> drain)
//   fifo_re     fifo read enable / pop           (drain -> fifo)
//   flush       synchronous discard request      (control -> drain)
//   m_valid     stream data valid                (drain -> sink)
//   m_ready     stream sink ready                (sink -> drain)
//   m_data      stream data                      (drain -> sink)
//   beat_count  words delivered, 16-bit wrap     (drain -> observer)
//
//   master : the drain stage itself
//   slave  : the surrounding environment (fifo, sink, control)
// -----------------------------------------------------------------------------
interface fifo_stream_out_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  fifo_re;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [15:0]           beat_count;

    modport master (
        input  fifo_empty, fifo_q, flush, m_ready,
        output fifo_re, m_valid, m_data, beat_count
    );

    modport slave (
        output fifo_empty, fifo_q, flush, m_ready,
        input  fifo_re, m_valid, m_data, beat_count
    );
endinterface

// File: rtl/fifo_stream_out.sv
// -----------------------------------------------------------------------------
// fifo_stream_out
//   Drain stage placed directly after a BRAM-backed fifo. It pops words with
//   fifo_re, absorbs the one-cycle RAM read latency and presents the words on a
//   valid/ready stream through a 2-entry skid buffer, sustaining one word per
//   clock. A synchronous flush drops buffered and in-flight words.
//
//   clk    single clock, also the fifo read clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_stream_out_if.master:
//            fifo_empty/fifo_q in, fifo_re out   (fifo read side)
//            flush in                            (discard request)
//            m_valid/m_data out, m_ready in      (stream side)
//            beat_count out                      (delivered-word counter)
// -----------------------------------------------------------------------------
module fifo_stream_out #(
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_stream_out_if.master  bus
);

    // Skid buffer state
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic [15:0]           beat_count_q, beat_count_d;

    // Per-cycle events
    logic       pop;
    logic       capture;
    logic       fifo_re;
    logic [2:0] credit;

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it
        // unassigned, which would otherwise infer a latch.
        occ_d        = occ_q;
        inflight_d   = inflight_q;
        head_d       = head_q;
        tail_d       = tail_q;
        mem_d        = mem_q;
        beat_count_d = beat_count_q;

        pop = (occ_q != 2'd0) && bus.m_ready;

        // Words owed after this edge: buffered + in flight - leaving now.
        // A new pop is only allowed if it still fits in the 2-entry buffer,
        // which is what makes overflow impossible.
        credit  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_re = rst_n && !bus.flush && !bus.fifo_empty && (credit < 3'd2);

        // The RAM word requested last cycle is on fifo_q now; flush kills it.
        capture = inflight_q && !bus.flush;

        if (bus.flush) begin
            occ_d  = 2'd0;
            head_d = 1'b0;
            tail_d = 1'b0;
        end else begin
            if (capture) begin
                mem_d[tail_q] = bus.fifo_q;
                tail_d        = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            occ_d = occ_q + {1'b0, capture} - {1'b0, pop};
        end

        inflight_d   = fifo_re;
        // A pop coinciding with flush was accepted by the sink, so it counts.
        beat_count_d = beat_count_q + 16'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            // NOTE: the two storage entries are reset because m_data must read
            // zero out of reset; a larger RAM would be left unreset.
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            beat_count_q <= 16'd0;
        end else begin
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            mem_q        <= mem_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign bus.fifo_re    = fifo_re;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = mem_q[head_q];
    assign bus.beat_count = beat_count_q;

    // The credit rule guarantees a free slot for every captured word.
    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && occ_q == 2'd2));

endmodule
